// File: rtl/digit_fifo_ctrl_pkg.sv
// Shared widths and output-stage operation encoding for the digit FIFO controller.
// DIGIT_W / RAM_AW match the defaults used by the digit RAM and the multiplier datapath.
package digit_fifo_ctrl_pkg;

  localparam int unsigned DIGIT_W       = 4;
  localparam int unsigned RAM_AW        = 7;
  localparam int unsigned AF_MARGIN_DEF = 4;

  // Per-cycle action on the head/skid stage: {load, pop}.
  typedef enum logic [1:0] {
    STG_HOLD = 2'b00,
    STG_POP  = 2'b01,
    STG_LOAD = 2'b10,
    STG_SWAP = 2'b11
  } stage_op_e;

  function automatic stage_op_e stage_op(input logic load, input logic pop);
    return stage_op_e'({load, pop});
  endfunction

endpackage

// File: rtl/digit_fifo_ctrl_skid_buf.sv
// Two-entry head/skid output stage. Absorbs the RAM read latency so the FIFO
// can deliver a digit every cycle; head is always the next digit to leave.
module digit_skid_buf
  import digit_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DIGIT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  pop,
  output logic [1:0]            stage_cnt,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] skid;
  stage_op_e             op;

  assign op        = stage_op(load, pop);
  assign out_valid = (stage_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_cnt <= '0;
      head      <= '0;
      skid      <= '0;
    end else if (flush) begin
      stage_cnt <= '0;
      head      <= '0;
      skid      <= '0;
    end else begin
      case (op)
        STG_POP: begin
          if (stage_cnt == 2'd2) head <= skid;
          stage_cnt <= stage_cnt - 2'd1;
        end
        STG_LOAD: begin
          if (stage_cnt == 2'd0) head <= load_data;
          else                   skid <= load_data;
          stage_cnt <= stage_cnt + 2'd1;
        end
        STG_SWAP: begin
          // Count is unchanged: one digit leaves while the fetched one lands behind it.
          if (stage_cnt == 2'd2) begin
            head <= skid;
            skid <= load_data;
          end else begin
            head <= load_data;
          end
        end
        default: ;
      endcase
    end
  end

  ap_stage_bound: assert property (@(posedge clk) disable iff (rst)
    stage_cnt <= 2'd2);
  ap_load_room: assert property (@(posedge clk) disable iff (rst)
    (load && !pop) |-> (stage_cnt < 2'd2));
  ap_pop_valid: assert property (@(posedge clk) disable iff (rst)
    pop |-> out_valid);

endmodule

// File: rtl/digit_fifo_ctrl.sv
// Valid/ready digit FIFO controller wrapped around an external single-clock RAM
// with a registered read address; owns pointers, RAM occupancy and fetch scheduling.
module digit_fifo_ctrl
  import digit_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DIGIT_W,
  parameter int unsigned ADDR_WIDTH = RAM_AW,
  parameter int unsigned AF_MARGIN  = AF_MARGIN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_digit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_digit,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int unsigned         DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LEVEL = (ADDR_WIDTH + 1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   ram_count;
  logic [ADDR_WIDTH:0]   ram_count_nxt;
  logic                  fetch_pend;
  logic                  push;
  logic                  pop;
  logic                  fetch;
  logic [1:0]            stage_cnt;
  logic [2:0]            stage_fill;

  assign in_ready = ~rst & ~flush & (ram_count < DEPTH_C);
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  // Occupancy the stage will have next cycle if nothing new is fetched now.
  assign stage_fill = 3'(stage_cnt) + 3'(fetch_pend) - 3'(pop);
  assign fetch      = (ram_count != '0) & ~flush & (stage_fill < 3'd2);

  assign ram_we    = push;
  assign ram_waddr = wr_ptr;
  assign ram_data  = in_digit;
  assign ram_raddr = rd_ptr;

  assign level = (ADDR_WIDTH + 2)'(ram_count) + (ADDR_WIDTH + 2)'(fetch_pend)
               + (ADDR_WIDTH + 2)'(stage_cnt);

  always_comb begin
    ram_count_nxt = ram_count;
    if (push && !fetch)      ram_count_nxt = ram_count + 1'b1;
    else if (fetch && !push) ram_count_nxt = ram_count - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_count   <= '0;
      fetch_pend  <= 1'b0;
      almost_full <= 1'b0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_count   <= '0;
      fetch_pend  <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PTR_ONE;
      if (fetch) rd_ptr <= rd_ptr + PTR_ONE;
      ram_count   <= ram_count_nxt;
      fetch_pend  <= fetch;
      almost_full <= (ram_count_nxt >= AF_LEVEL);
    end
  end

  // ram_q belongs to the fetch issued last cycle; flush drops it via the stage's own clear.
  digit_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .load      (fetch_pend),
    .load_data (ram_q),
    .pop       (pop),
    .stage_cnt (stage_cnt),
    .out_valid (out_valid),
    .head      (out_digit)
  );

  ap_no_push_full: assert property (@(posedge clk) disable iff (rst)
    (ram_count == DEPTH_C) |-> !push);
  ap_no_fetch_empty: assert property (@(posedge clk) disable iff (rst)
    fetch |-> (ram_count != '0));
  ap_ptr_gap: assert property (@(posedge clk) disable iff (rst)
    (wr_ptr - rd_ptr) == ram_count[ADDR_WIDTH-1:0]);
  ap_count_bound: assert property (@(posedge clk) disable iff (rst)
    ram_count <= DEPTH_C);
  ap_level_bound: assert property (@(posedge clk) disable iff (rst)
    level <= (ADDR_WIDTH + 2)'(DEPTH + 2));

endmodule
